// File: rtl/memory_responder.sv
// ============================================================================
//  Module      : memory_responder
//  Description : Multicycle byte-wide memory responder. Latches a read or
//                write request, waits a fixed latency, performs one RAM
//                access and pulses mem_ready with registered read data.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module memory_responder #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MEM_read,
    input  logic                  MEM_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  mem_ready,
    output logic                  mem_busy,
    output logic                  mem_err
);

    localparam int         c_depth    = 1 << ADDR_WIDTH;
    localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    op_q, op_d;          // 1 = write, 0 = read
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    ram_we;
    logic                    ram_re;

    logic [DATA_WIDTH-1:0]   ram_q [0:c_depth-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            if (ram_re) begin
                rdata_q <= ram_q[addr_q];
            end
        end
    end

    // RAM is never cleared; reset only blocks a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (ram_we && !rst) begin
            ram_q[addr_q] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MEM_read ^ MEM_write) begin
                    op_d    = MEM_write;
                    addr_d  = address;
                    wdata_d = write_data;
                    cnt_d   = c_cnt_init;
                    state_d = S_BUSY;
                end else if (MEM_read && MEM_write) begin
                    err_d = 1'b1;
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ram_we  = op_q;
                    ram_re  = !op_q;
                    ready_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign read_data = rdata_q;
    assign mem_ready = ready_q;
    assign mem_busy  = busy_q;
    assign mem_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_responder.sv
// ============================================================================
//  Module      : tb_memory_responder
//  Description : Self-checking bench for memory_responder (LATENCY 2 and 1).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memory_responder;

    logic        clk;
    logic        rst;
    // LATENCY = 2 instance
    logic        a_rd, a_wr;
    logic [12:0] a_addr;
    logic [7:0]  a_wdata;
    logic [7:0]  a_rdata;
    logic        a_ready, a_busy, a_err;
    // LATENCY = 1 instance
    logic        b_rd, b_wr;
    logic [12:0] b_addr;
    logic [7:0]  b_wdata;
    logic [7:0]  b_rdata;
    logic        b_ready, b_busy, b_err;

    int checks;
    int failures;

    memory_responder #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .LATENCY(2)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .MEM_read   (a_rd),
        .MEM_write  (a_wr),
        .address    (a_addr),
        .write_data (a_wdata),
        .read_data  (a_rdata),
        .mem_ready  (a_ready),
        .mem_busy   (a_busy),
        .mem_err    (a_err)
    );

    memory_responder #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .LATENCY(1)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .MEM_read   (b_rd),
        .MEM_write  (b_wr),
        .address    (b_addr),
        .write_data (b_wdata),
        .read_data  (b_rdata),
        .mem_ready  (b_ready),
        .mem_busy   (b_busy),
        .mem_err    (b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ctl = {rst, rd, wr}; exp = {ready, busy, err, check_rdata}
    typedef struct {
        logic [2:0]  ctl;
        logic [12:0] addr;
        logic [7:0]  wd;
        logic [3:0]  exp;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [2:0] ctl, input logic [12:0] a, input logic [7:0] d,
                       input logic [3:0] e, input logic [7:0] ed);
        vec_t v;
        v.ctl = ctl; v.addr = a; v.wd = d; v.exp = e; v.rdata = ed;
        vecs.push_back(v);
    endtask

    // Write held until ready, dropped on the ready cycle; read_data must not move.
    task automatic add_write(input logic [12:0] a, input logic [7:0] d,
                             input logic ck, input logic [7:0] cur);
        add(3'b001, a, d, {3'b010, ck}, cur);
        add(3'b001, a, d, {3'b010, ck}, cur);
        add(3'b001, a, d, {3'b110, ck}, cur);
        add(3'b000, 13'h0, 8'h00, {3'b000, ck}, cur);
    endtask

    task automatic add_read(input logic [12:0] a, input logic ckp,
                            input logic [7:0] prev, input logic [7:0] expv);
        add(3'b010, a, 8'h00, {3'b010, ckp}, prev);
        add(3'b010, a, 8'h00, {3'b010, ckp}, prev);
        add(3'b010, a, 8'h00, 4'b1101, expv);
        add(3'b000, 13'h0, 8'h00, 4'b0001, expv);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic b_write(input logic [12:0] a, input logic [7:0] d);
        int n;
        b_wr = 1'b1; b_addr = a; b_wdata = d;
        n = 0;
        do begin
            step();
            n++;
        end while (!b_ready && n < 20);
        check("b_write_ready", 32'(b_ready), 32'(1'b1));
        b_wr = 1'b0;
        step();
        check("b_write_idle", 32'(b_busy), 32'(1'b0));
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        a_rd = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
        b_rd = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;

        // Reset held two cycles with read asserted, then read taken on first edge
        add(3'b110, 13'h0123, 8'h00, 4'b0001, 8'h00);
        add(3'b110, 13'h0123, 8'h00, 4'b0001, 8'h00);
        add(3'b010, 13'h0123, 8'h00, 4'b0101, 8'h00);
        add(3'b010, 13'h0123, 8'h00, 4'b0101, 8'h00);
        add(3'b010, 13'h0123, 8'h00, 4'b1100, 8'h00);
        add(3'b000, 13'h0000, 8'h00, 4'b0000, 8'h00);
        // Write 0xA5 to 0x0123, read it back and hold
        add_write(13'h0123, 8'hA5, 1'b0, 8'h00);
        add_read(13'h0123, 1'b0, 8'h00, 8'hA5);
        // Prime 0x0040, then both strobes: error pulse, no access
        add_write(13'h0040, 8'h5A, 1'b1, 8'hA5);
        add(3'b011, 13'h0040, 8'hFF, 4'b0011, 8'hA5);
        add(3'b000, 13'h0000, 8'h00, 4'b0001, 8'hA5);
        add_read(13'h0040, 1'b1, 8'hA5, 8'h5A);
        // Prime top address, then reset on the access edge of a second write
        add_write(13'h1FFF, 8'h77, 1'b1, 8'h5A);
        add(3'b001, 13'h1FFF, 8'h3C, 4'b0101, 8'h5A);
        add(3'b001, 13'h1FFF, 8'h3C, 4'b0101, 8'h5A);
        add(3'b101, 13'h1FFF, 8'h3C, 4'b0001, 8'h00);
        add(3'b000, 13'h0000, 8'h00, 4'b0001, 8'h00);
        add(3'b000, 13'h0000, 8'h00, 4'b0001, 8'h00);
        add_read(13'h1FFF, 1'b1, 8'h00, 8'h77);
        // Inputs scrambled during BUSY: latched write 0x99 -> 0x0200 only
        add(3'b001, 13'h0200, 8'h99, 4'b0101, 8'h77);
        add(3'b000, 13'h0300, 8'h11, 4'b0101, 8'h77);
        add(3'b010, 13'h0301, 8'h22, 4'b1101, 8'h77);
        add(3'b000, 13'h0000, 8'h00, 4'b0001, 8'h77);
        add(3'b000, 13'h0000, 8'h00, 4'b0001, 8'h77);
        add_read(13'h0200, 1'b1, 8'h77, 8'h99);
        // Reset in DONE: ready drops, earlier write survives
        add(3'b010, 13'h0123, 8'h00, 4'b0101, 8'h99);
        add(3'b010, 13'h0123, 8'h00, 4'b0101, 8'h99);
        add(3'b010, 13'h0123, 8'h00, 4'b1101, 8'hA5);
        add(3'b100, 13'h0000, 8'h00, 4'b0001, 8'h00);
        add(3'b000, 13'h0000, 8'h00, 4'b0001, 8'h00);
        add_read(13'h0123, 1'b1, 8'h00, 8'hA5);

        foreach (vecs[i]) begin
            rst     = vecs[i].ctl[2];
            a_rd    = vecs[i].ctl[1];
            a_wr    = vecs[i].ctl[0];
            a_addr  = vecs[i].addr;
            a_wdata = vecs[i].wd;
            step();
            check($sformatf("v%0d_ready", i), 32'(a_ready), 32'(vecs[i].exp[3]));
            check($sformatf("v%0d_busy", i),  32'(a_busy),  32'(vecs[i].exp[2]));
            check($sformatf("v%0d_err", i),   32'(a_err),   32'(vecs[i].exp[1]));
            if (vecs[i].exp[0]) begin
                check($sformatf("v%0d_rdata", i), 32'(a_rdata), 32'(vecs[i].rdata));
            end
        end
        rst = 1'b0;
        a_rd = 1'b0; a_wr = 1'b0;

        // LATENCY=1: fill three words, then back-to-back reads every 3 edges
        for (int k = 0; k < 3; k++) begin
            b_write(13'(k), 8'(8'h30 + k));
        end
        for (int k = 0; k < 3; k++) begin
            b_rd = 1'b1; b_addr = 13'(k);
            step();
            check("b_busy_c0",  32'(b_busy),  32'(1'b1));
            check("b_ready_c0", 32'(b_ready), 32'(1'b0));
            step();
            check("b_busy_c1",  32'(b_busy),  32'(1'b1));
            check("b_ready_c1", 32'(b_ready), 32'(1'b1));
            check("b_rdata",    32'(b_rdata), 32'(8'h30 + k));
            b_rd = 1'b0;
            step();
            check("b_busy_c2",  32'(b_busy),  32'(1'b0));
            check("b_ready_c2", 32'(b_ready), 32'(1'b0));
            check("b_err",      32'(b_err),   32'(1'b0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
